// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared types for the multiply/divide sequencer
//
// Package def: operation encoding, sequencer states and the control-word
// strobe fields that the decoder maps onto the sequencer inputs.
package def;

  // op[1] selects divide, op[0] selects signed
  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } md_op;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state;

  typedef struct packed {
    logic start;
    logic wr_hi;
    logic wr_lo;
    logic rd_req;
    md_op op;
  } ctrl;

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative multiply/divide sequencer owning HI/LO
//
// Executes MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring) in W
// iteration cycles plus one sign-fix cycle, services MTHI/MTLO and stalls
// the pipeline while a result is pending.
//
// Ports:
//   CLK, RESET      clock, asynchronous active-high reset
//   START, OP       launch operation OP on A/B
//   A, B            rs / rt operands
//   WR_HI, WR_LO    MTHI / MTLO strobes (A is the data)
//   RD_REQ          MFHI/MFLO in execute
//   ABORT           kill the operation in flight, suppress strobes in IDLE
//   BUSY            registered, operation in flight
//   STALL           combinational hold request to the hazard logic
//   HI, LO          registered result pair
module muldiv_seq
  import def::*;
#(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic [1:0]   OP,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         WR_HI,
  input  logic         WR_LO,
  input  logic         RD_REQ,
  input  logic         ABORT,
  output logic         BUSY,
  output logic         STALL,
  output logic [W-1:0] HI,
  output logic [W-1:0] LO
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  md_state        r_state;
  logic           r_busy;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_work;     // product, or remainder:quotient
  logic [W-1:0]   r_opd;      // multiplicand or divisor magnitude
  logic [W-1:0]   r_a_raw;    // original dividend for divide-by-zero
  md_op           r_op;
  logic           r_sign_a;
  logic           r_sign_b;
  logic           r_div_zero;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;

  ctrl            w_ctrl;
  logic           w_sa;
  logic           w_sb;
  logic [W-1:0]   w_mag_a;
  logic [W-1:0]   w_mag_b;
  logic [W:0]     w_add;
  logic [2*W-1:0] w_mul_next;
  logic [W:0]     w_rem_sh;
  logic [W:0]     w_diff;
  logic           w_ok;
  logic [2*W-1:0] w_div_next;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_fix_hi;
  logic [W-1:0]   w_fix_lo;

  assign w_ctrl = '{start: START, wr_hi: WR_HI, wr_lo: WR_LO,
                    rd_req: RD_REQ, op: md_op'(OP)};

  assign BUSY  = r_busy;
  assign HI    = r_hi;
  assign LO    = r_lo;
  assign STALL = r_busy & (w_ctrl.start | w_ctrl.wr_hi | w_ctrl.wr_lo | w_ctrl.rd_req);

  always_comb begin
    // operand signs only matter for the signed ops
    w_sa    = w_ctrl.op[0] & A[W-1];
    w_sb    = w_ctrl.op[0] & B[W-1];
    w_mag_a = w_sa ? -A : A;
    w_mag_b = w_sb ? -B : B;

    // multiply: add multiplicand into upper half when LSB set, shift right
    w_add      = {1'b0, r_work[2*W-1:W]} + (r_work[0] ? {1'b0, r_opd} : {(W+1){1'b0}});
    w_mul_next = {w_add, r_work[W-1:1]};

    // divide: shift remainder:quotient left, trial-subtract divisor
    w_rem_sh   = r_work[2*W-1:W-1];
    w_diff     = w_rem_sh - {1'b0, r_opd};
    // a set top bit means the shifted remainder already exceeds any divisor
    w_ok       = w_rem_sh[W] | ~w_diff[W];
    w_div_next = {(w_ok ? w_diff[W-1:0] : w_rem_sh[W-1:0]), r_work[W-2:0], w_ok};

    // sign correction
    w_prod   = (r_sign_a ^ r_sign_b) ? -r_work : r_work;
    w_fix_hi = w_prod[2*W-1:W];
    w_fix_lo = w_prod[W-1:0];
    if (r_op[1]) begin
      w_fix_lo = (r_sign_a ^ r_sign_b) ? -r_work[W-1:0] : r_work[W-1:0];
      w_fix_hi = r_sign_a ? -r_work[2*W-1:W] : r_work[2*W-1:W];
      if (r_div_zero) begin
        w_fix_hi = r_a_raw;
        w_fix_lo = {W{1'b1}};
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_work     <= '0;
      r_opd      <= '0;
      r_a_raw    <= '0;
      r_op       <= MULTU;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ABORT) begin
            r_state <= IDLE;
          end else if (w_ctrl.start) begin
            r_state    <= RUN;
            r_busy     <= 1'b1;
            r_cnt      <= CW'(W - 1);
            r_op       <= w_ctrl.op;
            r_sign_a   <= w_sa;
            r_sign_b   <= w_sb;
            r_a_raw    <= A;
            r_div_zero <= w_ctrl.op[1] & (B == '0);
            r_work     <= {{W{1'b0}}, (w_ctrl.op[1] ? w_mag_a : w_mag_b)};
            r_opd      <= w_ctrl.op[1] ? w_mag_b : w_mag_a;
          end else begin
            if (w_ctrl.wr_hi) r_hi <= A;
            if (w_ctrl.wr_lo) r_lo <= A;
          end
        end
        RUN: begin
          if (ABORT) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_work <= r_op[1] ? w_div_next : w_mul_next;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == '0) r_state <= FIX;
          end
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (!ABORT) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed vector bench for muldiv_seq
module tb_muldiv_seq;
  import def::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         START = 1'b0;
  logic [1:0]   OP = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         WR_HI = 1'b0;
  logic         WR_LO = 1'b0;
  logic         RD_REQ = 1'b0;
  logic         ABORT = 1'b0;
  logic         BUSY;
  logic         STALL;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tv[11];

  muldiv_seq #(.W(W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .A(A), .B(B),
    .WR_HI(WR_HI), .WR_LO(WR_LO), .RD_REQ(RD_REQ), .ABORT(ABORT),
    .BUSY(BUSY), .STALL(STALL), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // START presented in the current cycle (edge t); result checked in t+W+2
  task automatic run_op(input int idx, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    bit busy_ok = 1'b1;
    bit hold_ok = 1'b1;
    START = 1'b1; OP = op; A = a; B = b;
    #1;
    chk($sformatf("v%0d stall_at_accept", idx), {63'b0, STALL}, 64'd0);
    tick();
    START = 1'b0; A = $urandom; B = $urandom;
    for (int i = 1; i <= W + 1; i++) begin
      if (BUSY !== 1'b1) busy_ok = 1'b0;
      if (HI !== m_hi || LO !== m_lo) hold_ok = 1'b0;
      tick();
    end
    chk($sformatf("v%0d busy_window", idx), {63'b0, busy_ok}, 64'd1);
    chk($sformatf("v%0d hilo_hold", idx), {63'b0, hold_ok}, 64'd1);
    chk($sformatf("v%0d busy_done", idx), {63'b0, BUSY}, 64'd0);
    chk($sformatf("v%0d hi", idx), {32'b0, HI}, {32'b0, ehi});
    chk($sformatf("v%0d lo", idx), {32'b0, LO}, {32'b0, elo});
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    bit stall_ok;

    tv[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tv[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    tv[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[3]  = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    tv[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tv[5]  = '{2'b00, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A};
    tv[6]  = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    tv[7]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tv[8]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    tv[9]  = '{2'b11, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
    tv[10] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    // reset state
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    RD_REQ = 1'b1;
    #1;
    chk("reset busy", {63'b0, BUSY}, 64'd0);
    chk("reset hi", {32'b0, HI}, 64'd0);
    chk("reset lo", {32'b0, LO}, 64'd0);
    chk("idle rd_req no stall", {63'b0, STALL}, 64'd0);
    RD_REQ = 1'b0;

    // MTHI + MTLO together
    @(negedge CLK);
    WR_HI = 1'b1; WR_LO = 1'b1; A = 32'h1234;
    tick();
    WR_HI = 1'b0; WR_LO = 1'b0;
    chk("mthi_mtlo hi", {32'b0, HI}, 64'h1234);
    chk("mthi_mtlo lo", {32'b0, LO}, 64'h1234);
    m_hi = 32'h1234; m_lo = 32'h1234;

    // back-to-back operations from the vector table
    for (int k = 0; k < 11; k++)
      run_op(k, tv[k].op, tv[k].a, tv[k].b, tv[k].hi, tv[k].lo);

    // RD_REQ held through an operation, with a stalled START at t+5
    START = 1'b1; OP = 2'b00; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    tick();
    START = 1'b0; RD_REQ = 1'b1;
    stall_ok = 1'b1;
    for (int i = 1; i <= W + 1; i++) begin
      if (i == 5) begin
        START = 1'b1; OP = 2'b10; A = 32'd100; B = 32'd7;
      end else begin
        START = 1'b0;
      end
      #1;
      if (STALL !== 1'b1 || BUSY !== 1'b1) stall_ok = 1'b0;
      tick();
    end
    START = 1'b0;
    #1;
    chk("rd stall window", {63'b0, stall_ok}, 64'd1);
    chk("rd stall released", {63'b0, STALL}, 64'd0);
    chk("rd new hi", {32'b0, HI}, 64'hFFFFFFFE);
    chk("rd new lo", {32'b0, LO}, 64'h00000001);
    RD_REQ = 1'b0;
    tick();
    chk("stalled start dropped", {63'b0, BUSY}, 64'd0);

    // preset, then abort mid-run
    WR_HI = 1'b1; WR_LO = 1'b1; A = 32'h1234;
    tick();
    WR_HI = 1'b0; WR_LO = 1'b0;
    START = 1'b1; OP = 2'b00; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    tick();
    START = 1'b0;
    repeat (9) tick();
    chk("abort busy before", {63'b0, BUSY}, 64'd1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort busy", {63'b0, BUSY}, 64'd0);
    chk("abort hi", {32'b0, HI}, 64'h1234);
    chk("abort lo", {32'b0, LO}, 64'h1234);
    repeat (30) tick();
    chk("abort hi later", {32'b0, HI}, 64'h1234);
    chk("abort busy later", {63'b0, BUSY}, 64'd0);

    // ABORT in IDLE suppresses START and WR_*
    START = 1'b1; WR_HI = 1'b1; WR_LO = 1'b1; A = 32'h55; ABORT = 1'b1;
    tick();
    START = 1'b0; WR_HI = 1'b0; WR_LO = 1'b0; ABORT = 1'b0;
    chk("idle abort busy", {63'b0, BUSY}, 64'd0);
    chk("idle abort hi", {32'b0, HI}, 64'h1234);
    chk("idle abort lo", {32'b0, LO}, 64'h1234);

    // asynchronous reset mid-operation
    START = 1'b1; OP = 2'b10; A = 32'd100; B = 32'd7;
    tick();
    START = 1'b0;
    repeat (19) tick();
    chk("reset busy before", {63'b0, BUSY}, 64'd1);
    RESET = 1'b1;
    #1;
    chk("async reset busy", {63'b0, BUSY}, 64'd0);
    chk("async reset hi", {32'b0, HI}, 64'd0);
    chk("async reset lo", {32'b0, LO}, 64'd0);
    tick();
    RESET = 1'b0;
    repeat (40) tick();
    chk("post reset hi", {32'b0, HI}, 64'd0);
    chk("post reset busy", {63'b0, BUSY}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer that owns the HI/LO register pair for the integer pipeline. It executes MULT, MULTU, DIV and DIVU in 32 iteration cycles and services MTHI/MTLO writes. It supplies HI/LO to the MFHI/MFLO path and raises a combinational stall to the hazard logic while a result is pending. It sits beside the ALU in the execute stage and is driven by the decoded control word.

## Interface
- `W`, default 32: operand and HI/LO width; the iteration count equals `W`.
- `CLK` in 1: clock; all state changes on the rising edge.
- `RESET` in 1: asynchronous, active-high.
- `START` in 1: launch the operation selected by `OP` on `A`/`B`.
- `OP` in 2: `def::md_op`. Encodings: MULTU=00, MULT=01, DIVU=10, DIV=11.
- `A` in W: rs value (multiplicand or dividend).
- `B` in W: rt value (multiplier or divisor).
- `WR_HI` in 1: MTHI strobe; `A` is written to HI.
- `WR_LO` in 1: MTLO strobe; `A` is written to LO.
- `RD_REQ` in 1: an MFHI or MFLO is in execute.
- `ABORT` in 1: pipeline flush or exception; kills the operation in flight.
- `BUSY` out 1: an operation is in flight.
- `STALL` out 1: combinational; equals `BUSY & (START | WR_HI | WR_LO | RD_REQ)`.
- `HI` out W: registered HI.
- `LO` out W: registered LO.

## Operation
- States, type `def::md_state`: IDLE, RUN, FIX.
- Reset values: state IDLE, `HI` = 0, `LO` = 0, `BUSY` = 0, iteration counter = 0.
- IDLE:
  - Priority is ABORT > START > WR_HI/WR_LO.
  - START latches the operand magnitudes, the op, and the sign flags, loads the counter with W-1, and goes to RUN.
  - WR_HI and WR_LO may be asserted together. Each updates its own register at the edge. No state change.
- RUN, one iteration per cycle:
  - Multiply: radix-2 shift-add on magnitudes into a 2W-bit product register.
  - Divide: restoring division on magnitudes, using a (W+1)-bit trial subtract and a 2W-bit remainder:quotient register.
  - The counter decrements each cycle. When the counter is 0, go to FIX.
- FIX, one cycle:
  - Apply the sign correction, then write HI/LO and return to IDLE.
  - MULT: negate the full 2W-bit product if the operand signs differ.
  - DIV: the quotient is negative when sign A XOR sign B; the remainder takes the sign of A.
  - Unsigned ops: no correction.
- Divide by zero (DIV or DIVU with B = 0): HI = A unchanged, LO = all ones. No sign correction, no trap.
- DIV of most-negative by -1: LO = 0x80000000, HI = 0. This wraps silently.
- ABORT:
  - In RUN or FIX: return to IDLE next edge. HI/LO keep their pre-START values.
  - In IDLE: suppresses START and WR_*.
- START, WR_* or RD_REQ while BUSY: not accepted, and STALL is high. The pipeline holds the instruction and re-presents it.
- RESET mid-operation: immediate return to the reset values. The partial result is discarded.

## Timing
- START is sampled at edge t.
  - RUN occupies cycles t+1 through t+W.
  - FIX occupies cycle t+W+1.
  - The new HI/LO are visible, and BUSY is low, from cycle t+W+2 (t+34 for W=32).
- BUSY is registered: high from cycle t+1 through t+W+1.
- An MFHI held by STALL reads the new value in the first cycle STALL is low. No bypass exists.
- WR_HI/WR_LO in IDLE: the new value is visible the cycle after the strobe.
- Back-to-back: a START presented in cycle t+W+2 is accepted. Throughput is one operation per W+2 cycles.
- `HI`/`LO` change only at a FIX edge, a WR_* edge, or reset.

## Structure
- Shared package `def` holds:
  - `md_op` (2-bit enum);
  - `md_state` (IDLE/RUN/FIX);
  - `ctrl` fields for the start/rd/wr strobes, so the decoder's control word maps onto them.
- Single module with no sub-module. The multiply and divide datapaths share the 2W-bit working register and the counter.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001 at t+34; BUSY high t+1..t+33.
- MULT -3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0 → HI = 0x00000064, LO = 0xFFFFFFFF.
- DIV 0x80000000 / -1 → LO = 0x80000000, HI = 0.
- RD_REQ held from t+1:
  - STALL high t+1..t+33, low at t+34 with the new HI.
  - A START at t+5 is stalled and does not disturb the operation in flight.
- WR_HI = WR_LO = 1 with A = 0x1234 in IDLE → HI = LO = 0x1234 the next cycle.
- HI/LO preset to 0x1234, then START:
  - ABORT at t+10 → IDLE at t+11, HI = LO = 0x1234.
  - RESET at t+20 → HI = LO = 0, BUSY = 0 immediately.
